// File: rtl/fp32_div_scheduler.sv
// Round-robin front end that time-shares one fp32 SRT divider between NUM_REQ requesters.
// dbg_state encoding: 0=IDLE, 1=LOAD, 2=RUN, 3=DONE.
module fp32_div_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DONE_FLAG = 15,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_dividend,
    input  logic [32*NUM_REQ-1:0]   req_divisor,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_quotient,
    output logic [ID_W-1:0]         resp_id,
    output logic [31:0]             div_dividend,
    output logic [31:0]             div_divisor,
    output logic                    div_rst_n,
    input  logic [5:0]              div_flag,
    input  logic [31:0]             div_quotient,
    output logic [1:0]              dbg_state,
    output logic [ID_W-1:0]         dbg_rr_ptr
);

    // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
    // valid never waits on ready, and a held valid keeps its payload stable until accepted.

    localparam int SW = ID_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   w_grant_idx;
    logic [ID_W-1:0]   w_next_ptr;
    logic              w_grant_found;
    logic              w_accept;
    logic              w_flag_done;
    logic [31:0]       r_dividend;
    logic [31:0]       r_divisor;
    logic [31:0]       r_resp_quotient;
    logic [ID_W-1:0]   r_resp_id;

    // Scan from the round-robin pointer upward, wrapping at NUM_REQ-1.
    always_comb begin
        logic [SW-1:0] v_scan;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        v_scan        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_scan = {1'b0, r_rr_ptr} + SW'(k);
            if (v_scan >= SW'(NUM_REQ)) begin
                v_scan = v_scan - SW'(NUM_REQ);
            end
            if (!w_grant_found && req_valid[v_scan[ID_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = v_scan[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_next_ptr = w_grant_idx + ID_W'(1);
        if (w_grant_idx == ID_W'(NUM_REQ - 1)) begin
            w_next_ptr = '0;
        end
    end

    assign w_accept    = (r_state == S_IDLE) && w_grant_found;
    assign w_flag_done = (div_flag == 6'(DONE_FLAG));

    always_comb begin
        req_ready = '0;
        if (w_accept && !rst) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_grant_found) w_next_state = S_LOAD;
            S_LOAD: w_next_state = S_RUN;
            S_RUN:  if (w_flag_done) w_next_state = S_DONE;
            S_DONE: if (resp_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // The divider output is only meaningful while its flag sits at DONE_FLAG, so capture exactly then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr        <= '0;
            r_dividend      <= '0;
            r_divisor       <= '0;
            r_resp_quotient <= '0;
            r_resp_id       <= '0;
        end else begin
            if (w_accept) begin
                r_dividend <= req_dividend[32*w_grant_idx +: 32];
                r_divisor  <= req_divisor[32*w_grant_idx +: 32];
                r_resp_id  <= w_grant_idx;
                r_rr_ptr   <= w_next_ptr;
            end
            if ((r_state == S_RUN) && w_flag_done) begin
                r_resp_quotient <= div_quotient;
            end
        end
    end

    assign resp_valid    = (r_state == S_DONE);
    assign resp_quotient = r_resp_quotient;
    assign resp_id       = r_resp_id;
    assign div_rst_n     = (r_state == S_RUN);
    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;
    assign dbg_state     = r_state;
    assign dbg_rr_ptr    = r_rr_ptr;

endmodule

// File: tb/tb_fp32_div_scheduler.sv
// Bench for fp32_div_scheduler: a behavioural divider stand-in plus a cycle-level model of
// arbitration, latency and response contents driven by directed and random requests.
module tb_fp32_div_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int DONE_FLAG = 15;
    localparam int ID_W      = 2;
    localparam int LAT       = DONE_FLAG + 2;

    logic                   clk;
    logic                   rst;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [32*NUM_REQ-1:0]  req_dividend;
    logic [32*NUM_REQ-1:0]  req_divisor;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [31:0]            resp_quotient;
    logic [ID_W-1:0]        resp_id;
    logic [31:0]            div_dividend;
    logic [31:0]            div_divisor;
    logic                   div_rst_n;
    logic [5:0]             div_flag = '0;
    logic [31:0]            div_quotient;
    logic [31:0]            div_golden;
    logic [1:0]             dbg_state;
    logic [ID_W-1:0]        dbg_rr_ptr;

    fp32_div_scheduler #(.NUM_REQ(NUM_REQ), .DONE_FLAG(DONE_FLAG), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_quotient(resp_quotient), .resp_id(resp_id),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_rst_n(div_rst_n),
        .div_flag(div_flag), .div_quotient(div_quotient),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- fp helpers (normal numbers only) ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Divider stand-in: flag counts while released, quotient is junk except at DONE_FLAG.
    always @(posedge clk) begin
        if (!div_rst_n) div_flag <= '0;
        else            div_flag <= div_flag + 6'd1;
    end
    always @* div_golden = r2f(f2r(div_dividend) / f2r(div_divisor));
    assign div_quotient = (div_flag == 6'(DONE_FLAG)) ? div_golden : {div_flag, 26'h1555555};

    // ---------------- reference model / scoreboard ----------------
    logic [ID_W+31:0] exp_q[$];
    int               grant_log[$];
    logic [31:0]      q_tab [NUM_REQ];
    int               cyc = 0;
    int               m_ptr = 0;
    int               m_acc = 0;
    bit               m_busy = 1'b0;
    int               last_grant = -1;
    int               n_resp = 0;
    logic [31:0]      last_q = '0;
    bit               refill = 1'b0;
    bit               rand_mode = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : mon
        int g;
        int d;
        int idx;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [1:0] exp_state;
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            exp_q.delete();
            last_grant = -1;
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_div_rst_n", div_rst_n, 0);
            chk("rst_req_ready", req_ready, 0);
        end else begin
            d = cyc - m_acc;
            g = -1;
            exp_rdy = '0;
            if (!m_busy) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            if (!m_busy)      exp_state = 2'd0;
            else if (d == 0)  exp_state = 2'd1;
            else if (d < LAT) exp_state = 2'd2;
            else              exp_state = 2'd3;
            chk("req_ready", req_ready, exp_rdy);
            chk("resp_valid", resp_valid, m_busy && d >= LAT);
            chk("div_rst_n", div_rst_n, m_busy && d >= 1 && d < LAT);
            chk("state", dbg_state, exp_state);
            chk("rr_ptr", dbg_rr_ptr, m_ptr);
            if (m_busy && d >= LAT && resp_valid) begin
                chk("resp_quotient", resp_quotient, exp_q[0][31:0]);
                chk("resp_id", resp_id, exp_q[0][ID_W+31:32]);
                if (resp_ready) begin
                    last_q = exp_q[0][31:0];
                    void'(exp_q.pop_front());
                    m_busy = 1'b0;
                    n_resp++;
                end
            end
            last_grant = g;
            if (g >= 0) begin
                exp_q.push_back({ID_W'(g), q_tab[g]});
                grant_log.push_back(g);
                m_busy = 1'b1;
                m_acc  = cyc + 1;
                m_ptr  = (g + 1) % NUM_REQ;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic gen_pair(output logic [31:0] a, output logic [31:0] b, output logic [31:0] q);
        q = {1'($urandom_range(1, 0)), 8'($urandom_range(170, 80)), 11'($urandom_range(2047, 0)), 12'd0};
        b = {1'($urandom_range(1, 0)), 8'($urandom_range(150, 100)), 11'($urandom_range(2047, 0)), 12'd0};
        a = r2f(f2r(q) * f2r(b));
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [31:0] q);
        req_dividend[32*i +: 32] = a;
        req_divisor[32*i +: 32]  = b;
        q_tab[i]     = q;
        req_valid[i] = 1'b1;
    endtask

    task automatic new_req(input int i);
        logic [31:0] a, b, q;
        gen_pair(a, b, q);
        set_req(i, a, b, q);
    endtask

    task automatic tick();
        int g;
        @(posedge clk);
        #1;
        g = last_grant;
        if (g >= 0) begin
            if (rand_mode) begin
                if ($urandom_range(9, 0) < 7) new_req(g);
                else req_valid[g] = 1'b0;
            end else if (refill) new_req(g);
            else req_valid[g] = 1'b0;
        end
        if (rand_mode) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i != g) begin
                    if (!req_valid[i]) begin
                        if ($urandom_range(3, 0) == 0) new_req(i);
                    end else if ($urandom_range(49, 0) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            resp_ready = ($urandom_range(3, 0) != 0);
        end
    endtask

    task automatic do_reset();
        refill    = 1'b0;
        rand_mode = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        resp_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((m_busy || req_valid != '0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, n < budget, 1);
    endtask

    task automatic wait_busy(input string tag, input int budget);
        int n = 0;
        while (!m_busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, m_busy, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int base;
        int g0;
        int got;
        rst          = 1'b1;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        resp_ready   = 1'b0;
        do_reset();

        // single request 6.0 / 2.0
        resp_ready = 1'b1;
        set_req(0, 32'h40C00000, 32'h40000000, 32'h40400000);
        wait_idle("t1_drain", 100);
        chk("t1_resp_count", n_resp, 1);
        chk("t1_quotient", last_q, 32'h40400000);

        // all requesters held valid: grants 0,1,2,3,0
        do_reset();
        resp_ready = 1'b1;
        g0 = grant_log.size();
        refill = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) new_req(i);
        n = 0;
        while (grant_log.size() - g0 < 5 && n < 300) begin
            tick();
            n++;
        end
        refill = 1'b0;
        for (int k = 0; k < 5; k++) begin
            got = (g0 + k < grant_log.size()) ? grant_log[g0 + k] : -1;
            chk("t2_grant_order", got, k % NUM_REQ);
        end
        wait_idle("t2_drain", 400);

        // backpressure in DONE
        do_reset();
        base = n_resp;
        new_req(0);
        wait_busy("t3_grant", 20);
        new_req(2);
        n = 0;
        while (!resp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("t3_resp_valid_seen", resp_valid, 1);
        repeat (10) tick();
        chk("t3_no_consume", n_resp, base);
        resp_ready = 1'b1;
        wait_idle("t3_drain", 200);
        chk("t3_resp_count", n_resp, base + 2);

        // pointer at 3, only requester 1 valid: scan wraps
        do_reset();
        resp_ready = 1'b1;
        new_req(2);
        wait_idle("t4_drain_a", 100);
        chk("t4_ptr_after_2", dbg_rr_ptr, 3);
        new_req(1);
        wait_idle("t4_drain_b", 100);
        chk("t4_last_grant", grant_log[grant_log.size()-1], 1);
        chk("t4_ptr_after_1", dbg_rr_ptr, 2);

        // reset in the 5th cycle of RUN drops the in-flight request
        do_reset();
        resp_ready = 1'b1;
        base = n_resp;
        new_req(0);
        wait_busy("t5_grant", 20);
        repeat (5) tick();
        rst = 1'b1;
        req_valid = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (25) tick();
        chk("t5_no_resp", n_resp, base);
        chk("t5_state_idle", dbg_state, 0);
        chk("t5_div_rst_n", div_rst_n, 0);
        set_req(0, 32'h3F800000, 32'h40800000, 32'h3E800000);
        wait_idle("t5_drain", 100);
        chk("t5_resp_count", n_resp, base + 1);
        chk("t5_quotient", last_q, 32'h3E800000);

        // random traffic across all requesters
        do_reset();
        g0 = grant_log.size();
        rand_mode = 1'b1;
        n = 0;
        while (grant_log.size() - g0 < 200 && n < 20000) begin
            tick();
            n++;
        end
        rand_mode  = 1'b0;
        resp_ready = 1'b1;
        chk("t6_grant_count", grant_log.size() - g0 >= 200, 1);
        wait_idle("t6_drain", 400);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
